// File: rtl/cdb_arbiter_if.sv
// Producer request lanes and CDB broadcast outputs of the CDB arbiter.
// The master side is the producer/snooper environment; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ROBEN_W = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*ROBEN_W-1:0] req_roben;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         req_exception;
    logic [NREQ-1:0]         req_ready;
    logic                    cdb_valid;
    logic [ROBEN_W-1:0]      cdb_roben;
    logic [DATA_W-1:0]       cdb_data;
    logic                    cdb_exception;
    logic [SRC_W-1:0]        cdb_src;
    logic [31:0]             contention_cycles;

    modport master (
        output req_valid, req_roben, req_data, req_exception,
        input  req_ready, cdb_valid, cdb_roben, cdb_data, cdb_exception, cdb_src,
        input  contention_cycles
    );

    modport slave (
        input  req_valid, req_roben, req_data, req_exception,
        output req_ready, cdb_valid, cdb_roben, cdb_data, cdb_exception, cdb_src,
        output contention_cycles
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small result FIFO per producer, drained round-robin
// (one head per cycle) onto a registered single-slot CDB broadcast.
module cdb_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned QDEPTH  = 2,
    parameter int unsigned ROBEN_W = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SUM_W = SRC_W + 1;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [ROBEN_W-1:0] mem_roben_q [NREQ][QDEPTH];
    logic [DATA_W-1:0]  mem_data_q  [NREQ][QDEPTH];
    logic               mem_exc_q   [NREQ][QDEPTH];

    logic [NREQ-1:0][PTR_W-1:0] head_q, head_d;
    logic [NREQ-1:0][PTR_W-1:0] tail_q, tail_d;
    logic [NREQ-1:0][CNT_W-1:0] count_q, count_d;
    logic [SRC_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                       cdb_valid_q, cdb_valid_d;
    logic [ROBEN_W-1:0]         cdb_roben_q, cdb_roben_d;
    logic [DATA_W-1:0]          cdb_data_q, cdb_data_d;
    logic                       cdb_exc_q, cdb_exc_d;
    logic [SRC_W-1:0]           cdb_src_q, cdb_src_d;
    logic [31:0]                contention_q, contention_d;

    logic [NREQ-1:0] nonempty;
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic            grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [SUM_W-1:0] cand;

    // Ready depends on registered occupancy only; a same-cycle pop never raises it.
    always_comb begin
        nonempty = '0;
        ready    = '0;
        push     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            nonempty[i] = (count_q[i] != '0);
            ready[i]    = (count_q[i] != CNT_W'(QDEPTH));
            push[i]     = bus.req_valid[i] && ready[i] && !flush &&
                          (bus.req_roben[i*ROBEN_W +: ROBEN_W] != '0);
        end
    end

    // Scan from rr_ptr upward, wrapping mod NREQ; first non-empty queue wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = {1'b0, rr_ptr_q} + SUM_W'(off);
            if (cand >= SUM_W'(NREQ)) begin
                cand = cand - SUM_W'(NREQ);
            end
            if (!grant_found && nonempty[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_found && !flush) begin
            pop[grant_idx] = 1'b1;
        end

        for (int unsigned i = 0; i < NREQ; i++) begin
            head_d[i]  = head_q[i] + PTR_W'(pop[i]);
            tail_d[i]  = tail_q[i] + PTR_W'(push[i]);
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end

        cdb_valid_d = 1'b0;
        cdb_roben_d = '0;
        cdb_data_d  = '0;
        cdb_exc_d   = 1'b0;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;

        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            rr_ptr_d = '0;
        end else if (grant_found) begin
            cdb_valid_d = 1'b1;
            cdb_roben_d = mem_roben_q[grant_idx][head_q[grant_idx]];
            cdb_data_d  = mem_data_q[grant_idx][head_q[grant_idx]];
            cdb_exc_d   = mem_exc_q[grant_idx][head_q[grant_idx]];
            cdb_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        // Counted on pre-update occupancy, and deliberately not cleared by flush.
        contention_d = contention_q + 32'($countones(nonempty) >= 2);
    end

    // Queue storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_roben_q[i][tail_q[i]] <= bus.req_roben[i*ROBEN_W +: ROBEN_W];
                mem_data_q[i][tail_q[i]]  <= bus.req_data[i*DATA_W +: DATA_W];
                mem_exc_q[i][tail_q[i]]   <= bus.req_exception[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_roben_q  <= '0;
            cdb_data_q   <= '0;
            cdb_exc_q    <= 1'b0;
            cdb_src_q    <= '0;
            contention_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_roben_q  <= cdb_roben_d;
            cdb_data_q   <= cdb_data_d;
            cdb_exc_q    <= cdb_exc_d;
            cdb_src_q    <= cdb_src_d;
            contention_q <= contention_d;
        end
    end

    assign bus.req_ready         = ready;
    assign bus.cdb_valid         = cdb_valid_q;
    assign bus.cdb_roben         = cdb_roben_q;
    assign bus.cdb_data          = cdb_data_q;
    assign bus.cdb_exception     = cdb_exc_q;
    assign bus.cdb_src           = cdb_src_q;
    assign bus.contention_cycles = contention_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-level reference model predicts each
// broadcast; a negedge monitor pops and compares whatever the DUT presents.
module tb_cdb_arbiter;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned QDEPTH  = 2;
    localparam int unsigned ROBEN_W = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SRC_W   = 1;

    typedef struct packed {
        logic [ROBEN_W-1:0] roben;
        logic [DATA_W-1:0]  data;
        logic               exc;
    } item_t;

    typedef struct {
        item_t       it;
        int unsigned src;
        int unsigned stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NREQ(NREQ), .ROBEN_W(ROBEN_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(
        .NREQ(NREQ), .QDEPTH(QDEPTH), .ROBEN_W(ROBEN_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    bit          saw_full1 = 1'b0;

    item_t           src_q [NREQ][$];
    bit [NREQ-1:0]   holding = '0;
    item_t           mq [NREQ][$];
    exp_t            exp_q [$];
    logic [NREQ-1:0] m_ready;
    logic [31:0]     m_cont;
    logic [ROBEN_W-1:0] seen [$];
    int unsigned     seen_stamp [$];

    function automatic item_t mk(input int unsigned r, input int unsigned d, input bit e);
        item_t t;
        t.roben = ROBEN_W'(r);
        t.data  = d;
        t.exc   = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: producer queues, a round-robin pointer and a contention counter.
    initial begin : model
        int unsigned w;
        int unsigned ne;
        bit          found;
        bit          rdy [NREQ];
        item_t       it;
        int unsigned rr;
        rr = 0;
        m_cont = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                for (int i = 0; i < NREQ; i++) mq[i].delete();
                rr = 0;
                m_cont = '0;
            end else begin
                ne = 0;
                for (int i = 0; i < NREQ; i++) if (mq[i].size() > 0) ne++;
                if (ne >= 2) m_cont = m_cont + 1;
                if (flush) begin
                    for (int i = 0; i < NREQ; i++) mq[i].delete();
                    rr = 0;
                end else begin
                    for (int i = 0; i < NREQ; i++) rdy[i] = (mq[i].size() < QDEPTH);
                    found = 1'b0;
                    w = 0;
                    for (int unsigned off = 0; off < NREQ; off++) begin
                        if (!found && mq[(rr + off) % NREQ].size() > 0) begin
                            found = 1'b1;
                            w = (rr + off) % NREQ;
                        end
                    end
                    if (found) begin
                        it = mq[w].pop_front();
                        exp_q.push_back('{it: it, src: w, stamp: cyc});
                        rr = (w + 1) % NREQ;
                    end
                    for (int i = 0; i < NREQ; i++) begin
                        it.roben = bus.req_roben[i*ROBEN_W +: ROBEN_W];
                        it.data  = bus.req_data[i*DATA_W +: DATA_W];
                        it.exc   = bus.req_exception[i];
                        if (bus.req_valid[i] && rdy[i] && it.roben != 0) mq[i].push_back(it);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) m_ready[i] = (mq[i].size() < QDEPTH);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.req_ready[1] === 1'b0) saw_full1 = 1'b1;
                chk("req_ready", 64'(bus.req_ready), 64'(m_ready));
                chk("contention", 64'(bus.contention_cycles), 64'(m_cont));
                if (bus.cdb_valid === 1'b1) begin
                    seen.push_back(bus.cdb_roben);
                    seen_stamp.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_broadcast actual roben=%0d required none",
                                 bus.cdb_roben);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.cdb_roben !== e.it.roben || bus.cdb_data !== e.it.data ||
                            bus.cdb_exception !== e.it.exc || bus.cdb_src !== SRC_W'(e.src) ||
                            cyc != e.stamp) begin
                            errors++;
                            $display({"FAIL broadcast actual roben=%0d data=%08h exc=%0b ",
                                      "src=%0d cyc=%0d required roben=%0d data=%08h exc=%0b ",
                                      "src=%0d cyc=%0d"},
                                     bus.cdb_roben, bus.cdb_data, bus.cdb_exception,
                                     bus.cdb_src, cyc, e.it.roben, e.it.data, e.it.exc,
                                     e.src, e.stamp);
                        end
                    end
                end else begin
                    chk("idle_fields_zero",
                        64'({bus.cdb_valid, bus.cdb_roben, bus.cdb_exception}), 64'd0);
                    chk("idle_data_zero", 64'(bus.cdb_data), 64'd0);
                    if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_broadcast actual none required roben=%0d",
                                 exp_q[0].it.roben);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Producers present their source-queue heads and hold them until accepted.
    // Flush or reset squashes whatever is being presented.
    task automatic run_cycles(input int n, input bit gaps);
        logic [NREQ-1:0] rdy;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() > 0 && (holding[i] || !gaps || $urandom_range(0, 3) != 0)) begin
                    bus.req_valid[i]                     = 1'b1;
                    bus.req_roben[i*ROBEN_W +: ROBEN_W]  = src_q[i][0].roben;
                    bus.req_data[i*DATA_W +: DATA_W]     = src_q[i][0].data;
                    bus.req_exception[i]                 = src_q[i][0].exc;
                    holding[i]                           = 1'b1;
                end else begin
                    bus.req_valid[i] = 1'b0;
                    holding[i]       = 1'b0;
                end
            end
            rdy = bus.req_ready;
            @(posedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (holding[i] && (rdy[i] || flush || !rst)) begin
                    void'(src_q[i].pop_front());
                    holding[i] = 1'b0;
                end
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin : main
        logic [31:0] c0;
        int unsigned n0, n1, bad;
        rst = 1'b0;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_roben = '0;
        bus.req_data = '0;
        bus.req_exception = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with both producers active.
        src_q[0].push_back(mk(5, 32'h55, 1'b0));
        src_q[0].push_back(mk(6, 32'h66, 1'b0));
        src_q[1].push_back(mk(7, 32'h77, 1'b1));
        src_q[1].push_back(mk(8, 32'h88, 1'b0));
        run_cycles(2, 1'b0);
        chk("reset_ready", 64'(bus.req_ready), 64'h3);
        chk("reset_valid", 64'(bus.cdb_valid), 64'h0);
        chk("reset_contention", 64'(bus.contention_cycles), 64'h0);
        chk("reset_src", 64'(bus.cdb_src), 64'h0);
        rst = 1'b1;
        seen.delete();
        run_cycles(3, 1'b0);
        chk("reset_no_bcast", 64'(seen.size()), 64'd0);

        // Single stream on producer 0: latency 2, then one per cycle.
        for (int k = 1; k <= 4; k++) src_q[0].push_back(mk(k, 32'h10 * k, 1'b0));
        seen.delete();
        seen_stamp.delete();
        c0 = cyc;
        run_cycles(8, 1'b0);
        chk("stream_count", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) begin
            chk("stream_order", 64'({seen[0], seen[1], seen[2], seen[3]}),
                64'({5'd1, 5'd2, 5'd3, 5'd4}));
            chk("stream_first_latency", 64'(seen_stamp[0] - c0), 64'd2);
            chk("stream_back_to_back", 64'(seen_stamp[3] - seen_stamp[0]), 64'd3);
        end

        // Round-robin from rr_ptr = 0 (a flush parks the pointer there).
        flush = 1'b1;
        run_cycles(1, 1'b0);
        flush = 1'b0;
        src_q[0].push_back(mk(3, 32'h300, 1'b0));
        src_q[0].push_back(mk(4, 32'h400, 1'b0));
        src_q[1].push_back(mk(7, 32'h700, 1'b0));
        src_q[1].push_back(mk(8, 32'h800, 1'b1));
        c0 = m_cont;
        seen.delete();
        run_cycles(7, 1'b0);
        chk("rr_count", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) begin
            chk("rr_order", 64'({seen[0], seen[1], seen[2], seen[3]}),
                64'({5'd3, 5'd7, 5'd4, 5'd8}));
        end
        chk("rr_contention_delta", 64'(32'(bus.contention_cycles - c0)), 64'd3);

        // Full queue: producer 1 backs up while producer 0 competes every cycle.
        for (int k = 0; k < 6; k++) src_q[0].push_back(mk(10 + k, 32'hA000 + k, 1'b0));
        for (int k = 0; k < 5; k++) src_q[1].push_back(mk(20 + k, 32'hB000 + k, k[0]));
        seen.delete();
        saw_full1 = 1'b0;
        run_cycles(16, 1'b0);
        n0 = 0;
        n1 = 0;
        bad = 0;
        foreach (seen[k]) begin
            if (seen[k] >= 10 && seen[k] <= 15) begin
                if (seen[k] != ROBEN_W'(10 + n0)) bad++;
                n0++;
            end else if (seen[k] >= 20 && seen[k] <= 24) begin
                if (seen[k] != ROBEN_W'(20 + n1)) bad++;
                n1++;
            end else begin
                bad++;
            end
        end
        chk("full_p0_count", 64'(n0), 64'd6);
        chk("full_p1_count", 64'(n1), 64'd5);
        chk("full_in_order", 64'(bad), 64'd0);
        chk("full_ready1_dropped", 64'(saw_full1), 64'd1);

        // Flush with entries queued and a same-cycle push of roben 9.
        src_q[0].push_back(mk(11, 32'h1111, 1'b0));
        src_q[0].push_back(mk(12, 32'h1212, 1'b0));
        src_q[1].push_back(mk(21, 32'h2121, 1'b0));
        src_q[1].push_back(mk(22, 32'h2222, 1'b0));
        run_cycles(2, 1'b0);
        src_q[0].push_back(mk(9, 32'h9999, 1'b0));
        flush = 1'b1;
        seen.delete();
        run_cycles(1, 1'b0);
        flush = 1'b0;
        chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("flush_ready", 64'(bus.req_ready), 64'h3);
        run_cycles(4, 1'b0);
        chk("flush_discarded", 64'(seen.size()), 64'd0);

        // ROBEN 0 is dropped, never queued.
        src_q[0].push_back(mk(0, 32'hDEAD, 1'b0));
        seen.delete();
        run_cycles(4, 1'b0);
        chk("roben0_no_bcast", 64'(seen.size()), 64'd0);
        chk("roben0_ready", 64'(bus.req_ready), 64'h3);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(0, 1) == 1)
                    src_q[i].push_back(mk($urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1))));
            end
            flush = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) != 0);
            run_cycles(1, 1'b1);
        end
        flush = 1'b0;
        rst = 1'b1;
        run_cycles(20, 1'b0);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) broadcast slot between result producers: ALU functional unit, memory unit, and future units. Each producer gets a small result queue. A round-robin arbiter drains one queue head per cycle onto a registered CDB broadcast, which the ROB, RS and load/store buffer snoop. A ROB flush discards all queued, uncommitted results.

## Interface
Parameters:
- NREQ, 2, number of requesters (index 0 = ALU, 1 = memory unit)
- QDEPTH, 2, entries per requester queue (power of two, ≥2)
- ROBEN_W, 5, ROB entry number width; ROBEN 0 means "no instruction"
- DATA_W, 32, result width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge)
- flush  in  1  ROB flush; synchronous queue/bus clear
- req_valid  in  NREQ  producer i presents a result
- req_roben  in  NREQ*ROBEN_W  producer i ROBEN, slice i
- req_data  in  NREQ*DATA_W  producer i result, slice i
- req_exception  in  NREQ  producer i exception bit
- req_ready  out  NREQ  queue i can accept this cycle
- cdb_valid  out  1  broadcast valid
- cdb_roben  out  ROBEN_W  broadcast ROBEN, 0 when invalid
- cdb_data  out  DATA_W  broadcast data, 0 when invalid
- cdb_exception  out  1  broadcast exception, 0 when invalid
- cdb_src  out  clog2(NREQ)  index of winning requester
- contention_cycles  out  32  count of cycles with ≥2 non-empty queues

## Operation
- Per-requester circular FIFO of {roben, data, exception}, with head/tail pointers and an occupancy count of 0..QDEPTH.
- req_ready[i] = (count[i] != QDEPTH). It is combinational from registered count only; a pop in the same cycle does not raise it.
- Push: req_valid[i] && req_ready[i] && roben_i != 0 && !flush. A request with roben 0 is silently dropped, not queued.
- Arbitration each cycle among non-empty queues. Priority starts at rr_ptr and wraps upward (rr_ptr, rr_ptr+1, … mod NREQ).
- The winner pops its head, and the head is registered into the cdb_* outputs. Then rr_ptr ← (winner+1) mod NREQ.
- If no queue is non-empty: cdb_valid←0, cdb_roben/data/exception←0, cdb_src holds, rr_ptr holds.
- Push and pop on the same queue in one cycle: count unchanged, both pointers advance, wrapping mod QDEPTH.
- contention_cycles increments (wrapping at 2^32) in each cycle where ≥2 queues have count>0 before the update. It is not cleared by flush.
- flush (rst high): all counts and pointers ← 0, cdb_valid/roben/data/exception ← 0, rr_ptr ← 0. Same-cycle pushes are discarded.
- rst low: everything flush clears, plus contention_cycles ← 0 and cdb_src ← 0. rst overrides flush.
- Reset mid-operation discards queued results with no broadcast.

## Timing
- Reset values: req_ready = all 1s, cdb_valid 0, cdb_roben 0, cdb_data 0, cdb_exception 0, cdb_src 0, contention_cycles 0.
- Latency: a result accepted at edge E is the earliest broadcast in the cycle following edge E+1. That is 2 cycles from presentation to visible broadcast, with no bypass.
- Throughput: 1 broadcast per cycle aggregate. A sole active requester streams 1 result/cycle with QDEPTH ≥ 2.
- Each broadcast is held exactly one cycle; there is no consumer back-pressure.
- Worst-case wait for a non-empty queue head is NREQ−1 grants.
- Requesters must hold valid/roben/data while req_ready is 0. Data is captured only on the accepting edge.
- flush asserted at edge F: cdb_valid is 0 in the cycle after F, and req_ready is all 1s after F.

## Test plan
- Reset: hold rst=0 for 2 cycles with req_valid=2'b11. Release. Required: cdb_valid=0, req_ready=2'b11, contention_cycles=0, no broadcast from pre-reset requests.
- Single stream: producer 0 pushes roben 1..4, data 0x10..0x40, on consecutive cycles. Required: broadcasts roben 1,2,3,4 on 4 consecutive cycles, the first exactly 2 cycles after the first presentation, cdb_src=0.
- Round-robin: both queues fill with 2 entries each (ALU roben 3,4; MEM roben 7,8, exception=1 on 8), rr_ptr=0. Required: broadcast order 3,7,4,8. cdb_exception=1 only on 8. contention_cycles increases by 3.
- Full queue: hold producer 1 valid for 5 cycles while producer 0 saturates the grants. Required: req_ready[1]=0 when count=2, no entry lost or duplicated, and in-order delivery per producer.
- Flush: with 2 entries queued on each producer, assert flush together with a new push of roben 9. Required: the next cycle has cdb_valid=0, req_ready=2'b11, and roben 9 never broadcast.
- ROBEN 0 filter: push roben 0, data 0xDEAD on producer 0. Required: no broadcast, count unchanged.
